// File: rtl/fb_scanout_pkg.sv
// Shared framebuffer constants: geometry defaults, word/pixel packing, fetch-state encoding.
// No logic; referenced by the scanout reader and the renderer's writer side.
// Keep encodings stable: both sides of the framebuffer port decode fetch_state_t.
package fb_scanout_pkg;
    localparam int H_ACTIVE_DEF = 720;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_BITS     = 8;
    localparam int PIX_PER_WORD = 8;
    localparam int WORD_BITS    = PIX_BITS * PIX_PER_WORD;
    localparam int ADDR_BITS    = 28;
    localparam int WCNT_BITS    = 16;
    localparam int FRAME_WORDS  = H_ACTIVE_DEF * V_ACTIVE_DEF / PIX_PER_WORD;

    typedef enum logic [1:0] {
        FS_IDLE      = 2'd0,
        FS_REQ       = 2'd1,
        FS_WAIT_DATA = 2'd2
    } fetch_state_t;

    // Number of 64-bit words covering one active frame.
    function automatic logic [WCNT_BITS-1:0] frame_words(input int h, input int v);
        return WCNT_BITS'(h * v / PIX_PER_WORD);
    endfunction
endpackage

// File: rtl/fb_word_fifo.sv
// Synchronous first-word-fall-through FIFO holding prefetched framebuffer words.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens the same cycle; flush wins over both.
module fb_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed, occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: fetches 64-bit words, buffers them, emits one 8-bit colour index per active pixel.
// Latency: pix_color/pix_valid are registered, one cycle after ce_pix && de.
// Backpressure: fetching pauses while the FIFO (counting the in-flight word) is full; an empty FIFO underflows.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int                   H_ACTIVE   = H_ACTIVE_DEF,
    parameter int                   V_ACTIVE   = V_ACTIVE_DEF,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [ADDR_BITS-1:0] FB_BASE    = 28'd0
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    output logic [ADDR_BITS-1:0] fb_rd_addr,
    output logic                 fb_rd_req,
    input  logic                 fb_rd_ready,
    input  logic [WORD_BITS-1:0] fb_rd_data,
    input  logic                 ce_pix,
    input  logic                 de,
    input  logic                 vs_start,
    output logic [PIX_BITS-1:0]  pix_color,
    output logic                 pix_valid,
    output logic                 underflow,
    output logic                 frame_done
);
    localparam logic [WCNT_BITS-1:0] FRAME_W = frame_words(H_ACTIVE, V_ACTIVE);
    localparam int                   CW      = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t          state;
    logic                  discard;
    logic [WCNT_BITS-1:0]  word_cnt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [WORD_BITS-1:0]  fifo_dout;
    logic                  in_flight;
    logic                  room;
    logic                  push;
    logic                  pop;
    logic                  pix_due;
    logic [WORD_BITS-1:0]  cur_word;
    logic [2:0]            byte_idx;
    logic                  cur_left;

    // An outstanding request already owns a FIFO slot, so a returning word always fits.
    assign in_flight = (state != FS_IDLE);
    assign room      = (int'(fifo_count) + int'(in_flight)) < FIFO_DEPTH;
    assign pix_due   = ce_pix && de;
    // vs_start beats a returning word: the old frame's data is thrown away.
    assign push      = (state == FS_WAIT_DATA) && fb_rd_ready && !discard && !vs_start;
    // After an underflow the FIFO is drained freely so fetching can run to the end of the frame.
    assign pop       = !vs_start && !fifo_empty && (underflow || (pix_due && !cur_left));

    fb_word_fifo #(
        .WIDTH (WORD_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .flush     (vs_start),
        .push      (push),
        .push_data (fb_rd_data),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    a_no_drop: assert property (@(posedge clk_sys) disable iff (!reset_n) !(push && fifo_full && !pop));

    // Fetch FSM: one request at a time over the ready/req handshake, address and word count advance per push.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FS_IDLE;
            fb_rd_req  <= 1'b0;
            fb_rd_addr <= FB_BASE;
            word_cnt   <= '0;
            discard    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (vs_start) begin
                word_cnt   <= '0;
                fb_rd_addr <= FB_BASE;
            end
            case (state)
                FS_IDLE: begin
                    if (!vs_start && room && (word_cnt < FRAME_W)) begin
                        state     <= FS_REQ;
                        fb_rd_req <= 1'b1;
                    end
                end
                FS_REQ: begin
                    if (vs_start) discard <= 1'b1;
                    if (!fb_rd_ready) begin
                        state     <= FS_WAIT_DATA;
                        fb_rd_req <= 1'b0;
                    end
                end
                FS_WAIT_DATA: begin
                    if (fb_rd_ready) begin
                        state   <= FS_IDLE;
                        discard <= 1'b0;
                        if (push) begin
                            fb_rd_addr <= fb_rd_addr + ADDR_BITS'(8);
                            word_cnt   <= word_cnt + 1'b1;
                            frame_done <= (word_cnt == FRAME_W - 1'b1);
                        end
                    end else if (vs_start) begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state     <= FS_IDLE;
                    fb_rd_req <= 1'b0;
                end
            endcase
        end
    end

    // Unpacker: walk bytes 0..7 of the current word, refilling from the FIFO head when it runs out.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pix_color <= '0;
            pix_valid <= 1'b0;
            underflow <= 1'b0;
            cur_word  <= '0;
            byte_idx  <= '0;
            cur_left  <= 1'b0;
        end else if (vs_start) begin
            pix_valid <= 1'b0;
            underflow <= 1'b0;
            byte_idx  <= '0;
            cur_left  <= 1'b0;
        end else begin
            pix_valid <= pix_due;
            if (pix_due) begin
                if (underflow) begin
                    pix_color <= '0;
                end else if (cur_left) begin
                    pix_color <= cur_word[{byte_idx, 3'b000} +: PIX_BITS];
                    byte_idx  <= byte_idx + 3'd1;
                    cur_left  <= (byte_idx != 3'd7);
                end else if (!fifo_empty) begin
                    pix_color <= fifo_dout[PIX_BITS-1:0];
                    cur_word  <= fifo_dout;
                    byte_idx  <= 3'd1;
                    cur_left  <= 1'b1;
                end else begin
                    pix_color <= '0;
                    underflow <= 1'b1;
                end
            end
        end
    end
endmodule
